// File: rtl/outstanding_reply_unit.sv
// Outstanding-reply tracker: merges read requests per line tag, issues one memory
// fetch per tag, and fans each fill response out as one reply per waiting requester.
module outstanding_reply_unit #(
    parameter int ENTRIES = 4,
    parameter int WAITERS = 4,
    parameter int TAG_W   = 24,
    parameter int DEST_W  = 4,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [DEST_W-1:0] req_src,
    input  logic              req_outstanding,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [TAG_W-1:0]  mem_req_tag,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [TAG_W-1:0]  rsp_tag,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DEST_W-1:0] out_dest,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] out_data,
    output logic              full,
    output logic              err_orphan_req,
    output logic              err_orphan_rsp,
    output logic              o_dbg_state
);

    localparam int CNT_W  = $clog2(WAITERS + 1);
    localparam int WIDX_W = (WAITERS > 1) ? $clog2(WAITERS) : 1;
    localparam int EIDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    // Handshakes: a transfer happens on a valid/ready pair only when both are high
    // at a rising clk edge; valid never waits on ready.

    logic [ENTRIES-1:0] r_valid;
    logic [ENTRIES-1:0] r_issued;
    logic [TAG_W-1:0]   r_tag   [ENTRIES];
    logic [CNT_W-1:0]   r_wcnt  [ENTRIES];
    logic [DEST_W-1:0]  r_dest  [ENTRIES][WAITERS];

    state_t             r_state;
    logic [EIDX_W-1:0]  r_didx;
    logic [WIDX_W-1:0]  r_widx;
    logic [TAG_W-1:0]   r_dtag;
    logic [DATA_W-1:0]  r_ddata;
    logic               r_hold;
    logic [EIDX_W-1:0]  r_hold_idx;
    logic               r_err_req;
    logic               r_err_rsp;

    logic               w_hit;
    logic [EIDX_W-1:0]  w_hit_idx;
    logic               w_free_any;
    logic [EIDX_W-1:0]  w_free_idx;
    logic               w_iss_any;
    logic [EIDX_W-1:0]  w_iss_idx;
    logic               w_rsp_hit;
    logic [EIDX_W-1:0]  w_rsp_idx;
    logic               w_drain_block;
    logic               w_hit_full;
    logic [WIDX_W-1:0]  w_hit_slot;
    logic [EIDX_W-1:0]  w_sel;
    logic               w_req_hs;
    logic               w_mem_hs;
    logic               w_rsp_hs;
    logic               w_out_hs;
    logic               w_last;

    // Descending scans so the lowest matching index is the one that sticks.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free_any = 1'b0;
        w_free_idx = '0;
        w_iss_any  = 1'b0;
        w_iss_idx  = '0;
        w_rsp_hit  = 1'b0;
        w_rsp_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == req_tag)) begin
                w_hit     = 1'b1;
                w_hit_idx = EIDX_W'(i);
            end
            if (!r_valid[i]) begin
                w_free_any = 1'b1;
                w_free_idx = EIDX_W'(i);
            end
            if (r_valid[i] && !r_issued[i]) begin
                w_iss_any = 1'b1;
                w_iss_idx = EIDX_W'(i);
            end
            if (r_valid[i] && r_issued[i] && (r_tag[i] == rsp_tag)) begin
                w_rsp_hit = 1'b1;
                w_rsp_idx = EIDX_W'(i);
            end
        end
    end

    assign w_drain_block = (r_state == S_DRAIN) && (req_tag == r_dtag);
    assign w_hit_full    = (r_wcnt[w_hit_idx] == CNT_W'(WAITERS));
    assign w_hit_slot    = r_wcnt[w_hit_idx][WIDX_W-1:0];
    assign req_ready     = !w_drain_block && (w_hit ? !w_hit_full : w_free_any);
    assign w_req_hs      = req_valid && req_ready;

    // A stalled fetch keeps its entry so a newly allocated lower index cannot
    // change mem_req_tag underneath the memory port.
    assign w_sel         = r_hold ? r_hold_idx : w_iss_idx;
    assign mem_req_valid = r_hold || w_iss_any;
    assign mem_req_tag   = r_tag[w_sel];
    assign w_mem_hs      = mem_req_valid && mem_req_ready;

    assign rsp_ready     = (r_state == S_IDLE);
    assign w_rsp_hs      = rsp_valid && rsp_ready;

    assign out_valid     = (r_state == S_DRAIN);
    assign out_dest      = r_dest[r_didx][r_widx];
    assign out_tag       = r_dtag;
    assign out_data      = r_ddata;
    assign w_out_hs      = out_valid && out_ready;
    assign w_last        = ((CNT_W'(r_widx) + CNT_W'(1)) == r_wcnt[r_didx]);

    assign full           = &r_valid;
    assign err_orphan_req = r_err_req;
    assign err_orphan_rsp = r_err_rsp;
    assign o_dbg_state    = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= '0;
            r_issued   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]  <= '0;
                r_wcnt[i] <= '0;
                for (int j = 0; j < WAITERS; j++) begin
                    r_dest[i][j] <= '0;
                end
            end
            r_state    <= S_IDLE;
            r_didx     <= '0;
            r_widx     <= '0;
            r_dtag     <= '0;
            r_ddata    <= '0;
            r_hold     <= 1'b0;
            r_hold_idx <= '0;
            r_err_req  <= 1'b0;
            r_err_rsp  <= 1'b0;
        end else begin
            if (w_req_hs) begin
                if (w_hit) begin
                    r_dest[w_hit_idx][w_hit_slot] <= req_src;
                    r_wcnt[w_hit_idx]             <= r_wcnt[w_hit_idx] + CNT_W'(1);
                end else begin
                    r_valid[w_free_idx]     <= 1'b1;
                    r_issued[w_free_idx]    <= 1'b0;
                    r_tag[w_free_idx]       <= req_tag;
                    r_wcnt[w_free_idx]      <= CNT_W'(1);
                    r_dest[w_free_idx][0]   <= req_src;
                    if (req_outstanding) begin
                        r_err_req <= 1'b1;
                    end
                end
            end

            if (w_mem_hs) begin
                r_issued[w_sel] <= 1'b1;
            end
            r_hold     <= mem_req_valid && !mem_req_ready;
            r_hold_idx <= w_sel;

            case (r_state)
                S_IDLE: begin
                    if (w_rsp_hs) begin
                        if (w_rsp_hit) begin
                            r_state <= S_DRAIN;
                            r_didx  <= w_rsp_idx;
                            r_dtag  <= rsp_tag;
                            r_ddata <= rsp_data;
                            r_widx  <= '0;
                        end else begin
                            r_err_rsp <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_out_hs) begin
                        if (w_last) begin
                            r_valid[r_didx]  <= 1'b0;
                            r_issued[r_didx] <= 1'b0;
                            r_wcnt[r_didx]   <= '0;
                            r_widx           <= '0;
                            r_state          <= S_IDLE;
                        end else begin
                            r_widx <= r_widx + WIDX_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_outstanding_reply_unit.sv
// Bench for outstanding_reply_unit: directed scenarios plus a random phase, all
// checked each cycle against a tag-keyed transaction model.
module tb_outstanding_reply_unit;

    localparam int ENTRIES = 4;
    localparam int WAITERS = 4;
    localparam int TAG_W   = 24;
    localparam int DEST_W  = 4;
    localparam int DATA_W  = 32;

    typedef logic [TAG_W-1:0] tag_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [TAG_W-1:0]  req_tag = '0;
    logic [DEST_W-1:0] req_src = '0;
    logic              req_outstanding = 1'b0;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b1;
    logic [TAG_W-1:0]  mem_req_tag;
    logic              rsp_valid = 1'b0;
    logic              rsp_ready;
    logic [TAG_W-1:0]  rsp_tag = '0;
    logic [DATA_W-1:0] rsp_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DEST_W-1:0] out_dest;
    logic [TAG_W-1:0]  out_tag;
    logic [DATA_W-1:0] out_data;
    logic              full;
    logic              err_orphan_req;
    logic              err_orphan_rsp;
    logic              o_dbg_state;

    outstanding_reply_unit #(
        .ENTRIES(ENTRIES), .WAITERS(WAITERS), .TAG_W(TAG_W), .DEST_W(DEST_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
        .req_src(req_src), .req_outstanding(req_outstanding),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_tag(mem_req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_dest(out_dest),
        .out_tag(out_tag), .out_data(out_data),
        .full(full), .err_orphan_req(err_orphan_req), .err_orphan_rsp(err_orphan_rsp),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending reads keyed by tag, never by entry slot.
    int          m_cnt  [tag_t];
    bit          m_iss  [tag_t];
    logic [15:0] m_srcs [tag_t];
    int          m_npend = 0;
    bit          m_drain = 0;
    tag_t        m_dtag;
    logic [DATA_W-1:0] m_ddata;
    int          m_widx = 0;
    bit          m_err_req = 0;
    bit          m_err_rsp = 0;
    tag_t        mem_q[$];
    logic [DEST_W-1:0] out_log[$];
    bit          prev_stall = 0;
    tag_t        prev_mtag;
    int          n_out_hs = 0;
    int          n_mem_hs = 0;

    logic s_req_ready, s_mem_valid, s_rsp_ready, s_out_valid, s_full, s_err_req, s_err_rsp;
    tag_t s_mem_tag;
    logic [DEST_W-1:0] s_out_dest;
    logic [DATA_W-1:0] s_out_data;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt.delete();
        m_iss.delete();
        m_srcs.delete();
        m_npend    = 0;
        m_drain    = 0;
        m_widx     = 0;
        m_err_req  = 0;
        m_err_rsp  = 0;
        mem_q.delete();
        prev_stall = 0;
    endtask

    task automatic set_idle();
        req_valid       = 1'b0;
        req_outstanding = 1'b0;
        rsp_valid       = 1'b0;
        mem_req_ready   = 1'b1;
        out_ready       = 1'b1;
    endtask

    // One clock: compare at the falling edge, advance the model for the coming rising edge.
    task automatic step();
        logic exp_rr, any_un, legal, pre_drain;
        logic [15:0] s;
        tag_t t;
        @(negedge clk);
        pre_drain = m_drain;
        exp_rr = !(m_drain && (req_tag == m_dtag)) &&
                 (m_cnt.exists(req_tag) ? (m_cnt[req_tag] < WAITERS) : (m_npend < ENTRIES));
        any_un = 1'b0;
        foreach (m_cnt[k]) if (!m_iss[k]) any_un = 1'b1;
        legal = m_cnt.exists(mem_req_tag) ? !m_iss[mem_req_tag] : 1'b0;
        s_req_ready = req_ready;  s_mem_valid = mem_req_valid; s_mem_tag  = mem_req_tag;
        s_rsp_ready = rsp_ready;  s_out_valid = out_valid;     s_out_dest = out_dest;
        s_out_data  = out_data;   s_full      = full;
        s_err_req   = err_orphan_req; s_err_rsp = err_orphan_rsp;

        chk("req_ready", req_ready, exp_rr);
        chk("full", full, m_npend == ENTRIES);
        chk("mem_req_valid", mem_req_valid, any_un);
        if (mem_req_valid && any_un) chk("mem_req_tag_pending", legal, 1'b1);
        if (prev_stall && mem_req_valid) chk("mem_req_tag_stable", mem_req_tag, prev_mtag);
        chk("rsp_ready", rsp_ready, !m_drain);
        chk("out_valid", out_valid, m_drain);
        if (m_drain) begin
            s = m_srcs[m_dtag];
            chk("out_dest", out_dest, s[m_widx*4 +: 4]);
            chk("out_tag", out_tag, m_dtag);
            chk("out_data", out_data, m_ddata);
        end
        chk("err_orphan_req", err_orphan_req, m_err_req);
        chk("err_orphan_rsp", err_orphan_rsp, m_err_rsp);

        prev_stall = mem_req_valid && !mem_req_ready;
        prev_mtag  = mem_req_tag;
        if (out_valid && out_ready) begin
            out_log.push_back(out_dest);
            n_out_hs++;
        end
        if (m_drain && out_ready) begin
            m_widx++;
            if (m_widx == m_cnt[m_dtag]) begin
                m_cnt.delete(m_dtag);
                m_iss.delete(m_dtag);
                m_srcs.delete(m_dtag);
                m_npend--;
                m_drain = 0;
            end
        end
        if (rsp_valid && !pre_drain) begin
            if (m_cnt.exists(rsp_tag) && m_iss[rsp_tag]) begin
                m_drain = 1;
                m_dtag  = rsp_tag;
                m_ddata = rsp_data;
                m_widx  = 0;
            end else begin
                m_err_rsp = 1;
            end
            if (mem_q.size() > 0 && mem_q[0] == rsp_tag) void'(mem_q.pop_front());
        end
        if (req_valid && exp_rr) begin
            t = req_tag;
            if (m_cnt.exists(t)) begin
                s = m_srcs[t];
                s[m_cnt[t]*4 +: 4] = req_src;
                m_srcs[t] = s;
                m_cnt[t]  = m_cnt[t] + 1;
            end else begin
                m_cnt[t]  = 1;
                m_iss[t]  = 0;
                m_srcs[t] = {12'h000, req_src};
                m_npend++;
                if (req_outstanding) m_err_req = 1;
            end
        end
        if (mem_req_valid && mem_req_ready && legal) begin
            m_iss[mem_req_tag] = 1;
            mem_q.push_back(mem_req_tag);
            n_mem_hs++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_req(input tag_t tag, input logic [DEST_W-1:0] src, input logic outst);
        bit ok = 0;
        req_valid = 1'b1; req_tag = tag; req_src = src; req_outstanding = outst;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (s_req_ready) ok = 1;
        end
        req_valid = 1'b0; req_outstanding = 1'b0;
        chk("req_accepted", ok, 1'b1);
    endtask

    task automatic send_rsp(input tag_t tag, input logic [DATA_W-1:0] data);
        bit ok = 0;
        rsp_valid = 1'b1; rsp_tag = tag; rsp_data = data;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (s_rsp_ready) ok = 1;
        end
        rsp_valid = 1'b0;
        chk("rsp_accepted", ok, 1'b1);
    endtask

    // Called just after a rising edge; reset lands between edges.
    task automatic pulse_reset();
        set_idle();
        req_tag = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_ready", rsp_ready, 1'b1);
        chk("rst_err_req", err_orphan_req, 1'b0);
        chk("rst_err_rsp", err_orphan_rsp, 1'b0);
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int n0;
        logic [DEST_W-1:0] d0;
        logic [DATA_W-1:0] v0;

        #1;
        chk("init_out_valid", out_valid, 1'b0);
        chk("init_full", full, 1'b0);
        chk("init_req_ready", req_ready, 1'b1);
        chk("init_mem_req_valid", mem_req_valid, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single miss, fetch, and one reply
        n0 = n_out_hs;
        send_req(24'h1A, 4'd2, 1'b0);
        step();
        chk("t1_mem_valid", s_mem_valid, 1'b1);
        chk("t1_mem_tag", s_mem_tag, 24'h1A);
        send_rsp(24'h1A, 32'hDEADBEEF);
        step();
        chk("t1_out_valid", s_out_valid, 1'b1);
        chk("t1_out_dest", s_out_dest, 4'd2);
        chk("t1_out_data", s_out_data, 32'hDEADBEEF);
        step();
        chk("t1_out_done", s_out_valid, 1'b0);
        chk("t1_one_out", n_out_hs - n0, 1);

        // Three requesters merged behind one fetch
        mem_req_ready = 1'b0;
        n0 = n_mem_hs;
        send_req(24'h5, 4'd1, 1'b0);
        send_req(24'h5, 4'd3, 1'b1);
        send_req(24'h5, 4'd7, 1'b1);
        run(2);
        mem_req_ready = 1'b1;
        run(4);
        chk("t2_one_fetch", n_mem_hs - n0, 1);
        out_log.delete();
        send_rsp(24'h5, 32'h0000_55AA);
        run(6);
        chk("t2_out_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("t2_dest0", out_log[0], 4'd1);
            chk("t2_dest1", out_log[1], 4'd3);
            chk("t2_dest2", out_log[2], 4'd7);
        end
        chk("t2_no_err_on_hit", s_err_req, 1'b0);

        // Capacity limits
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_req(tag_t'(24'h100 + i), 4'd0, 1'b0);
        step();
        chk("t3_full", s_full, 1'b1);
        req_valid = 1'b1; req_tag = 24'h104; req_src = 4'd9;
        step();
        chk("t3_fifth_tag_stall", s_req_ready, 1'b0);
        req_valid = 1'b0;
        for (int i = 1; i < 4; i++) send_req(24'h100, 4'(i), 1'b0);
        req_valid = 1'b1; req_tag = 24'h100; req_src = 4'd9;
        step();
        chk("t3_fifth_waiter_stall", s_req_ready, 1'b0);
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        run(6);
        for (int i = 0; i < 4; i++) send_rsp(tag_t'(24'h100 + i), $urandom());
        run(8);
        chk("t3_full_cleared", s_full, 1'b0);

        // Reply backpressure
        n0 = n_out_hs;
        send_req(24'h20, 4'd1, 1'b0);
        send_req(24'h20, 4'd4, 1'b0);
        run(3);
        out_ready = 1'b0;
        send_rsp(24'h20, 32'hCAFE0020);
        d0 = 4'd1;
        v0 = 32'hCAFE0020;
        for (int i = 0; i < 5; i++) begin
            req_valid = (i < 2);
            req_tag   = (i == 0) ? 24'h20 : 24'h21;
            req_src   = 4'd6;
            step();
            chk("t4_out_valid_held", s_out_valid, 1'b1);
            chk("t4_out_dest_held", s_out_dest, d0);
            chk("t4_out_data_held", s_out_data, v0);
            chk("t4_rsp_ready_low", s_rsp_ready, 1'b0);
            if (i == 0) chk("t4_same_tag_stalled", s_req_ready, 1'b0);
            if (i == 1) chk("t4_other_tag_taken", s_req_ready, 1'b1);
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        run(4);
        chk("t4_two_outs", n_out_hs - n0, 2);
        send_rsp(24'h21, 32'h2121_2121);
        run(3);

        // Error flags
        pulse_reset();
        n0 = n_out_hs;
        send_rsp(24'h99, 32'h1234_5678);
        run(2);
        chk("t5_orphan_rsp", s_err_rsp, 1'b1);
        chk("t5_no_out", n_out_hs - n0, 0);
        send_req(24'h30, 4'd5, 1'b1);
        step();
        chk("t5_orphan_req", s_err_req, 1'b1);
        chk("t5_alloc_fetch", s_mem_valid, 1'b1);
        chk("t5_alloc_tag", s_mem_tag, 24'h30);
        run(2);
        send_rsp(24'h30, 32'h3030_3030);
        run(3);

        // Reset in the middle of a three-reply drain
        pulse_reset();
        send_req(24'h40, 4'd1, 1'b0);
        send_req(24'h40, 4'd2, 1'b0);
        send_req(24'h40, 4'd3, 1'b0);
        run(3);
        send_rsp(24'h40, 32'h4040_4040);
        step();
        chk("t6_first_reply", s_out_dest, 4'd1);
        n0 = n_out_hs;
        pulse_reset();
        req_valid = 1'b1; req_tag = 24'h50; req_src = 4'd8;
        step();
        chk("t6_req_after_rst", s_req_ready, 1'b1);
        req_valid = 1'b0;
        run(3);
        chk("t6_no_more_replies", n_out_hs - n0, 0);
        send_rsp(24'h50, 32'h5050_5050);
        run(3);

        // Random traffic
        pulse_reset();
        for (int c = 0; c < 3000; c++) begin
            req_valid       = $urandom_range(0, 1);
            req_tag         = tag_t'(24'h600 + $urandom_range(0, 5));
            req_src         = 4'($urandom_range(0, 15));
            req_outstanding = ($urandom_range(0, 3) == 0);
            mem_req_ready   = $urandom_range(0, 1);
            out_ready       = ($urandom_range(0, 9) < 7);
            if (mem_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                rsp_valid = 1'b1; rsp_tag = mem_q[0]; rsp_data = $urandom();
            end else if ($urandom_range(0, 39) == 0) begin
                rsp_valid = 1'b1; rsp_tag = 24'hABC; rsp_data = $urandom();
            end else begin
                rsp_valid = 1'b0;
            end
            step();
        end
        set_idle();
        for (int c = 0; c < 3000 && (m_npend != 0 || mem_q.size() != 0); c++) begin
            rsp_valid = (mem_q.size() > 0);
            if (mem_q.size() > 0) begin
                rsp_tag = mem_q[0]; rsp_data = $urandom();
            end
            step();
        end
        rsp_valid = 1'b0;
        run(3);
        chk("rand_all_served", m_npend, 0);
        chk("rand_no_fetch_left", mem_q.size(), 0);
        chk("rand_not_full", s_full, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
